// File: rtl/rsa_keygen_ctrl.sv
// RSA key-generation sequencer: obtains P/Q from a prime generator, forms n and phi on a
// shared multiplier, then asks a modular-inverse unit for d, retrying with a stepped seed.
module rsa_keygen_ctrl #(
  parameter int unsigned             WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0]   E_VALUE     = 32'd65537,
  parameter int unsigned             MAX_RETRIES = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [WORD_WIDTH/2-1:0]              seed,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     attempts,
  output logic                                 pg_start,
  output logic [WORD_WIDTH/2-1:0]              pg_seed,
  input  logic                                 pg_done,
  input  logic [WORD_WIDTH/2-1:0]              pg_p,
  input  logic [WORD_WIDTH/2-1:0]              pg_q,
  output logic                                 mul_start,
  output logic [WORD_WIDTH/2-1:0]              mul_a,
  output logic [WORD_WIDTH/2-1:0]              mul_b,
  input  logic                                 mul_done,
  input  logic [WORD_WIDTH-1:0]                mul_result,
  output logic                                 inv_start,
  output logic [WORD_WIDTH-1:0]                inv_a,
  output logic [WORD_WIDTH-1:0]                inv_m,
  input  logic                                 inv_done,
  input  logic                                 inv_valid,
  input  logic [WORD_WIDTH-1:0]                inv_result,
  output logic [WORD_WIDTH-1:0]                n_out,
  output logic [WORD_WIDTH-1:0]                e_out,
  output logic [WORD_WIDTH-1:0]                d_out
);

  localparam int unsigned HW = WORD_WIDTH / 2;
  localparam int unsigned AW = $clog2(MAX_RETRIES + 1);
  localparam logic [AW-1:0] MAX_ATT = AW'(MAX_RETRIES);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PG_REQ, ST_PG_WAIT, ST_CHECK, ST_MN_REQ, ST_MN_WAIT, ST_MP_REQ,
    ST_MP_WAIT, ST_INV_REQ, ST_INV_WAIT, ST_RETRY, ST_DONE, ST_FAIL
  } state_e;

  state_e          state_q;
  logic [HW-1:0]   seed_q, p_q, q_q, pg_seed_q, mul_a_q, mul_b_q;
  logic [AW-1:0]   attempts_q;
  logic [WORD_WIDTH-1:0] n_q, phi_q, inv_a_q, n_out_q, e_out_q, d_out_q;
  logic            busy_q, done_q, error_q, pg_start_q, mul_start_q, inv_start_q;
  logic [HW-1:0]   seed_d;

  assign seed_d = seed_q + HW'(2);

  // Sequencer state, datapath registers and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      p_q         <= '0;
      q_q         <= '0;
      pg_seed_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      attempts_q  <= '0;
      n_q         <= '0;
      phi_q       <= '0;
      inv_a_q     <= '0;
      n_out_q     <= '0;
      e_out_q     <= '0;
      d_out_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pg_start_q  <= 1'b0;
      mul_start_q <= 1'b0;
      inv_start_q <= 1'b0;
    end else begin
      pg_start_q  <= 1'b0;
      mul_start_q <= 1'b0;
      inv_start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            seed_q     <= seed;
            pg_seed_q  <= seed;
            attempts_q <= AW'(1);
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            n_out_q    <= '0;
            e_out_q    <= '0;
            d_out_q    <= '0;
            pg_start_q <= 1'b1;
            state_q    <= ST_PG_REQ;
          end
        end
        ST_PG_REQ: state_q <= ST_PG_WAIT;
        ST_PG_WAIT: begin
          if (pg_done) begin
            p_q     <= pg_p;
            q_q     <= pg_q;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if ((p_q == q_q) || !p_q[0] || !q_q[0]) begin
            state_q <= ST_RETRY;
          end else begin
            mul_a_q     <= p_q;
            mul_b_q     <= q_q;
            mul_start_q <= 1'b1;
            state_q     <= ST_MN_REQ;
          end
        end
        ST_MN_REQ: state_q <= ST_MN_WAIT;
        ST_MN_WAIT: begin
          if (mul_done) begin
            n_q         <= mul_result;
            mul_a_q     <= p_q - HW'(1);
            mul_b_q     <= q_q - HW'(1);
            mul_start_q <= 1'b1;
            state_q     <= ST_MP_REQ;
          end
        end
        ST_MP_REQ: state_q <= ST_MP_WAIT;
        ST_MP_WAIT: begin
          if (mul_done) begin
            phi_q <= mul_result;
            // A modulus not above E cannot yield a usable private exponent.
            if (E_VALUE >= mul_result) begin
              state_q <= ST_RETRY;
            end else begin
              inv_a_q     <= E_VALUE;
              inv_start_q <= 1'b1;
              state_q     <= ST_INV_REQ;
            end
          end
        end
        ST_INV_REQ: state_q <= ST_INV_WAIT;
        ST_INV_WAIT: begin
          if (inv_done) begin
            if (inv_valid) begin
              n_out_q <= n_q;
              e_out_q <= E_VALUE;
              d_out_q <= inv_result;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RETRY;
            end
          end
        end
        ST_RETRY: begin
          if (attempts_q == MAX_ATT) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            n_out_q <= '0;
            e_out_q <= '0;
            d_out_q <= '0;
            state_q <= ST_FAIL;
          end else begin
            seed_q     <= seed_d;
            pg_seed_q  <= seed_d;
            attempts_q <= attempts_q + AW'(1);
            pg_start_q <= 1'b1;
            state_q    <= ST_PG_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign attempts  = attempts_q;
  assign pg_start  = pg_start_q;
  assign pg_seed   = pg_seed_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign inv_start = inv_start_q;
  assign inv_a     = inv_a_q;
  assign inv_m     = phi_q;
  assign n_out     = n_out_q;
  assign e_out     = e_out_q;
  assign d_out     = d_out_q;

endmodule

// File: doc/rsa_keygen_ctrl.md
Name: rsa_keygen_ctrl

Overview:
Top-level sequencer for RSA key generation. It drives prime_generator to obtain P and Q, then sequences a shared external multiplier to form n = P·Q and phi = (P−1)(Q−1). It then launches an external modular-inverse unit to compute d = E⁻¹ mod phi. Invalid prime pairs and non-invertible E trigger automatic retries with a stepped seed, up to a bounded number of attempts.

Parameters:
WORD_WIDTH, 32, key modulus width; P, Q and seed are WORD_WIDTH/2 bits.
E_VALUE, 65537, public exponent, WORD_WIDTH bits.
MAX_RETRIES, 8, maximum generation attempts before the block reports an error (≥1).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  request key generation; sampled only in IDLE, DONE or FAIL
seed  in  WORD_WIDTH/2  initial seed, latched on accepted start
busy  out  1  high from accepted start until DONE or FAIL is entered
done  out  1  level; high while in DONE
error  out  1  level; high while in FAIL
attempts  out  $clog2(MAX_RETRIES+1)  number of attempts started in the current run
pg_start  out  1  one-cycle pulse to prime_generator
pg_seed  out  WORD_WIDTH/2  seed to prime_generator, stable from pg_start until pg_done
pg_done  in  1  prime_generator completion
pg_p, pg_q  in  WORD_WIDTH/2 each  generated primes, valid when pg_done=1
mul_start  out  1  one-cycle pulse to multiplier
mul_a, mul_b  out  WORD_WIDTH/2 each  multiplier operands, stable until mul_done
mul_done  in  1  multiplier completion
mul_result  in  WORD_WIDTH  product, valid when mul_done=1
inv_start  out  1  one-cycle pulse to modular-inverse unit
inv_a, inv_m  out  WORD_WIDTH each  operand (E_VALUE) and modulus (phi)
inv_done  in  1  inverse completion
inv_valid  in  1  with inv_done: 1 = inverse exists (gcd = 1)
inv_result  in  WORD_WIDTH  inverse value
n_out, e_out, d_out  out  WORD_WIDTH each  key outputs; meaningful only while done=1

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, including e_out. Internal registers (seed_reg, P, Q, n, phi, retry count) cleared. Mid-operation reset aborts immediately. Pending sub-unit completions are ignored after reset.
- States: IDLE, PG_REQ, PG_WAIT, CHECK, MN_REQ, MN_WAIT, MP_REQ, MP_WAIT, INV_REQ, INV_WAIT, RETRY, DONE, FAIL.
- IDLE/DONE/FAIL with start=1 at an edge: latch seed into seed_reg, set attempts=1, clear done/error, set busy, go to PG_REQ. start is ignored in all other states.
- *_REQ states: the matching *_start is high for exactly that one cycle; operands are registered and held until the matching *_WAIT state exits. Each *_WAIT state samples only its own done input; done inputs are ignored outside their WAIT state.
- PG_REQ: pg_seed=seed_reg. PG_WAIT: on pg_done, latch P=pg_p, Q=pg_q, go to CHECK.
- CHECK (1 cycle): if P==Q, P[0]==0, or Q[0]==0, go to RETRY; otherwise go to MN_REQ.
- MN_REQ: mul_a=P, mul_b=Q. MN_WAIT: on mul_done, n=mul_result, go to MP_REQ.
- MP_REQ: mul_a=P−1, mul_b=Q−1. MP_WAIT: on mul_done, phi=mul_result. If E_VALUE ≥ phi, go to RETRY; otherwise go to INV_REQ.
- INV_REQ: inv_a=E_VALUE, inv_m=phi. INV_WAIT: on inv_done, if inv_valid=1, latch d=inv_result and go to DONE; if inv_valid=0, go to RETRY.
- RETRY (1 cycle): if attempts==MAX_RETRIES, go to FAIL. Otherwise seed_reg = seed_reg+2 (modulo 2^(WORD_WIDTH/2), wraps), attempts+1, go to PG_REQ.
- DONE: done=1, busy=0; n_out=n, e_out=E_VALUE, d_out=d, held until next accepted start.
- FAIL: error=1, busy=0, key outputs 0.
- Minimum latency from start to done, with all sub-units completing 1 cycle after request: 9 cycles.

Test Plan:
1. Nominal run (E_VALUE=17). seed=0x11EA; the prime_generator model returns P=61, Q=53 → mul sees 61×53 then 60×52; n_out=3233, e_out=17, d_out=2753; done=1, attempts=1, exactly one pulse on each *_start per request.
2. Duplicate primes. The first attempt returns P=Q=61 → no mul_start is issued; a second pg_start is issued with pg_seed=0x11EC. The second attempt returns 61/53 → done=1, attempts=2.
3. Non-invertible E. The model returns inv_valid=0 on every attempt, with MAX_RETRIES=2 → exactly 2 pg_start pulses, then error=1, done=0, busy=0, n_out=d_out=0.
4. start held high for 5 cycles during PG_WAIT → no extra pg_start, seed unchanged. A fresh start after done re-runs the sequence and drops done on acceptance.
5. rst driven low mid-MN_WAIT (asynchronous, between clock edges) → all outputs 0 immediately. A late mul_done is ignored. A later start completes normally.
6. Seed wrap. seed=0xFFFF, the first attempt returns an even P → the retry issues pg_seed=0x0001.
